// File: rtl/ddr_responder_pkg.sv
// Shared types and constants for the DDR responder slice: FSM state
// encoding, bus widths, and the LFSR seed/step used for latency jitter.
package ddr_responder_pkg;

  localparam int DDR_INDEX_W = 19;   // ddr_index is [18:0]
  localparam int DDR_WORD_W  = 64;
  localparam int DDR_BEATS   = 8;    // default 64-bit words per burst

  localparam logic [7:0] DDR_LFSR_SEED = 8'hA5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    BEAT = 2'd2,
    DONE = 2'd3
  } ddr_resp_state_t;

  // One step of the 8-bit Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1.
  function automatic logic [7:0] lfsr8_next(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

endpackage

// File: rtl/ddr_responder_if.sv
// DDR command/response bundle between the core-side channel arbiter
// (master) and the memory responder (slave).
interface ddr_responder_if
  import ddr_responder_pkg::*;
#(
  parameter int BEATS = DDR_BEATS
);
  logic                         ddr_chip_enable;
  logic [DDR_INDEX_W-1:0]       ddr_index;
  logic                         ddr_write_enable;
  logic                         ddr_burst_mode;
  logic [DDR_WORD_W-1:0]        ddr_opstore_write_mask;
  logic [DDR_WORD_W-1:0]        ddr_opstore_write_data;
  logic [DDR_WORD_W-1:0]        ddr_opload_read_data;
  logic [BEATS*DDR_WORD_W-1:0]  ddr_pc_read_inst;
  logic                         ddr_operation_done;
  logic                         ddr_ready;

  modport master (
    output ddr_chip_enable, ddr_index, ddr_write_enable, ddr_burst_mode,
           ddr_opstore_write_mask, ddr_opstore_write_data,
    input  ddr_opload_read_data, ddr_pc_read_inst, ddr_operation_done, ddr_ready
  );

  modport slave (
    input  ddr_chip_enable, ddr_index, ddr_write_enable, ddr_burst_mode,
           ddr_opstore_write_mask, ddr_opstore_write_data,
    output ddr_opload_read_data, ddr_pc_read_inst, ddr_operation_done, ddr_ready
  );

endinterface

// File: rtl/ddr_resp_lfsr.sv
// 8-bit Fibonacci LFSR with step enable and synchronous reset to a fixed
// seed; supplies pseudo-random extra wait cycles to the DDR responder.
module ddr_resp_lfsr
  import ddr_responder_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       en,
  output logic [7:0] lfsr_o
);

  logic [7:0] lfsr_q, lfsr_d;

  // Advance one step per enable.
  always_comb begin
    lfsr_d = lfsr_q;
    if (en) lfsr_d = lfsr8_next(lfsr_q);
  end

  // State register, reseeded on reset.
  always_ff @(posedge clock) begin
    if (reset) lfsr_q <= DDR_LFSR_SEED;
    else       lfsr_q <= lfsr_d;
  end

  assign lfsr_o = lfsr_q;

endmodule

// File: rtl/ddr_responder.sv
// DDR slave responder: serves masked 64-bit stores, 64-bit loads and
// BURST_BEATS-word instruction bursts from an internal word array with a
// programmable accept-to-done latency.
// Optional build macro DDR_RESP_JITTER_EN adds 0..3 LFSR-driven wait
// cycles per command. Memory contents are not reset.
module ddr_responder
  import ddr_responder_pkg::*;
#(
  parameter int ADDR_W        = 14,
  parameter int READ_LATENCY  = 3,
  parameter int WRITE_LATENCY = 2,
  parameter int BURST_BEATS   = DDR_BEATS
)(
  input  logic           clock,
  input  logic           reset,
  ddr_responder_if.slave bus
);

  localparam int WORD_W = DDR_WORD_W;
  localparam int CNT_W  = 16;
  localparam int BEAT_W = (BURST_BEATS > 1) ? $clog2(BURST_BEATS) : 1;

  ddr_resp_state_t   state_q, state_d;
  logic              ready_q, ready_d;
  logic              done_q, done_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              we_q, we_d;
  logic              burst_q, burst_d;
  logic [WORD_W-1:0] mask_q, mask_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;

  logic              accept;
  logic [1:0]        jitter;
  logic [CNT_W-1:0]  lat;

  logic [WORD_W-1:0] mem [2**ADDR_W];
  logic [WORD_W-1:0] rd_q;
  logic [ADDR_W-1:0] rd_addr;
  logic              store_commit;

  logic [WORD_W-1:0]             beat_buf_q [BURST_BEATS];
  logic [BURST_BEATS*WORD_W-1:0] beat_flat;
  logic [WORD_W-1:0]             load_q;
  logic [BURST_BEATS*WORD_W-1:0] inst_q;
  logic                          load_sel, burst_sel;

  // Index bits above ADDR_W are ignored: the array is addressed modulo 2^ADDR_W.
  logic unused_idx_hi;
  assign unused_idx_hi = ^bus.ddr_index[DDR_INDEX_W-1:ADDR_W];

  assign accept = ready_q & bus.ddr_chip_enable;

`ifdef DDR_RESP_JITTER_EN
  logic [7:0] lfsr_val;
  logic [5:0] lfsr_unused;
  ddr_resp_lfsr u_lfsr (
    .clock  (clock),
    .reset  (reset),
    .en     (accept),
    .lfsr_o (lfsr_val)
  );
  assign jitter      = lfsr_val[1:0];
  assign lfsr_unused = lfsr_val[7:2];
`else
  assign jitter = 2'd0;
`endif

  // Total accept-to-done wait for the command being offered this cycle.
  always_comb begin
    lat = bus.ddr_write_enable ? CNT_W'(WRITE_LATENCY) : CNT_W'(READ_LATENCY);
    lat = lat + CNT_W'(jitter);
  end

  // Next-state logic: IDLE -> WAIT -> (BEAT) -> DONE -> IDLE. The counter
  // holds the cycles remaining after the current one, so a latency of 1
  // skips WAIT entirely.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    beat_d  = beat_q;
    idx_d   = idx_q;
    we_d    = we_q;
    burst_d = burst_q;
    mask_d  = mask_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          idx_d   = bus.ddr_index[ADDR_W-1:0];
          we_d    = bus.ddr_write_enable;
          // A store with the burst flag set is still a single store.
          burst_d = bus.ddr_burst_mode & ~bus.ddr_write_enable;
          mask_d  = bus.ddr_opstore_write_mask;
          wdata_d = bus.ddr_opstore_write_data;
          beat_d  = '0;
          cnt_d   = lat - CNT_W'(1);
          if (lat == CNT_W'(1)) state_d = burst_d ? BEAT : DONE;
          else                  state_d = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = burst_q ? BEAT : DONE;
      end
      BEAT: begin
        beat_d = beat_q + BEAT_W'(1);
        if (beat_q == BEAT_W'(BURST_BEATS - 1)) begin
          beat_d  = '0;
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
    done_d  = (state_d == DONE);
  end

  // Control registers; reset abandons any in-flight command.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      beat_q  <= '0;
      idx_q   <= '0;
      we_q    <= 1'b0;
      burst_q <= 1'b0;
      mask_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      beat_q  <= beat_d;
      idx_q   <= idx_d;
      we_q    <= we_d;
      burst_q <= burst_d;
      mask_q  <= mask_d;
      wdata_q <= wdata_d;
    end
  end

  // Address is issued one cycle ahead so the registered read lands in the
  // cycle that consumes it (beat k sees mem[idx+k]; DONE sees mem[idx]).
  assign rd_addr = (state_d == BEAT) ? (idx_d + ADDR_W'(beat_d)) : idx_d;

  // Stores commit in DONE unless reset discards them.
  assign store_commit = (state_q == DONE) && we_q && !reset;

  // Word array: read-modify-write for masked stores, registered read port.
  always_ff @(posedge clock) begin
    if (store_commit) mem[idx_q] <= (rd_q & ~mask_q) | (wdata_q & mask_q);
    rd_q <= mem[rd_addr];
  end

  // Collect one burst word per BEAT cycle into its slot.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < BURST_BEATS; k++) beat_buf_q[k] <= '0;
    end else if (state_q == BEAT) begin
      beat_buf_q[beat_q] <= rd_q;
    end
  end

  for (genvar gi = 0; gi < BURST_BEATS; gi++) begin : g_flat
    assign beat_flat[gi*WORD_W +: WORD_W] = beat_buf_q[gi];
  end

  assign load_sel  = (state_q == DONE) && !we_q && !burst_q;
  assign burst_sel = (state_q == DONE) && burst_q;

  // Hold registers keep the last completed load/burst result.
  always_ff @(posedge clock) begin
    if (reset) begin
      load_q <= '0;
      inst_q <= '0;
    end else begin
      if (load_sel)  load_q <= rd_q;
      if (burst_sel) inst_q <= beat_flat;
    end
  end

  // Fresh data is presented in the DONE cycle itself, then held.
  assign bus.ddr_opload_read_data = load_sel  ? rd_q      : load_q;
  assign bus.ddr_pc_read_inst     = burst_sel ? beat_flat : inst_q;
  assign bus.ddr_operation_done   = done_q;
  assign bus.ddr_ready            = ready_q;

endmodule

// File: tb/tb_ddr_responder.sv
// Directed self-checking bench for ddr_responder: reset state, store/load
// latency and data, masked stores, burst wrap, busy-ignore and mid-op reset.
module tb_ddr_responder;
  import ddr_responder_pkg::*;

  localparam int ADDR_W = 14;
  localparam int RL     = 3;
  localparam int WL     = 2;
  localparam int BEATS  = 8;
  localparam int DEPTH  = 2**ADDR_W;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_pass  = 0;
  int   n_total = 0;

  always #5 clock = ~clock;

  ddr_responder_if #(.BEATS(BEATS)) bus ();

  ddr_responder #(
    .ADDR_W        (ADDR_W),
    .READ_LATENCY  (RL),
    .WRITE_LATENCY (WL),
    .BURST_BEATS   (BEATS)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_lat(input string tag, input int lat, input int base);
`ifdef DDR_RESP_JITTER_EN
    check(tag, {511'd0, (lat >= base && lat <= base + 3)}, 512'd1);
`else
    check(tag, lat, base);
`endif
  endtask

  // Issue one command in the next cycle and wait (bounded) for its done.
  // Returns with the bench positioned in the done cycle.
  task automatic do_op(input string tag, input logic we, input logic burst,
                       input logic [18:0] idx, input logic [63:0] mask,
                       input logic [63:0] data, output int lat);
    @(negedge clock);
    check({tag, "_ready"}, bus.ddr_ready, 1);
    check({tag, "_idle_done"}, bus.ddr_operation_done, 0);
    bus.ddr_chip_enable        = 1'b1;
    bus.ddr_write_enable       = we;
    bus.ddr_burst_mode         = burst;
    bus.ddr_index              = idx;
    bus.ddr_opstore_write_mask = mask;
    bus.ddr_opstore_write_data = data;
    @(negedge clock);
    bus.ddr_chip_enable = 1'b0;
    lat = 1;
    while (bus.ddr_operation_done !== 1'b1 && lat < 40) begin
      @(negedge clock);
      lat++;
    end
    $display("op %s we=%0d burst=%0d idx=%0h latency=%0d", tag, we, burst, idx, lat);
  endtask

  initial begin
    int lat;
    int dones;
    logic [511:0] exp_inst;
    logic [18:0]  w;

    bus.ddr_chip_enable        = 1'b0;
    bus.ddr_write_enable       = 1'b0;
    bus.ddr_burst_mode         = 1'b0;
    bus.ddr_index              = '0;
    bus.ddr_opstore_write_mask = '0;
    bus.ddr_opstore_write_data = '0;

    // 1. Reset held three cycles, then released.
    repeat (3) @(negedge clock);
    check("rst_ready", bus.ddr_ready, 0);
    check("rst_done", bus.ddr_operation_done, 0);
    reset = 1'b0;
    @(negedge clock);
    check("post_rst_ready", bus.ddr_ready, 1);
    check("post_rst_done", bus.ddr_operation_done, 0);
    check("post_rst_load", bus.ddr_opload_read_data, 0);
    check("post_rst_inst", bus.ddr_pc_read_inst, 0);

    // 2. Full-mask store then load back.
    do_op("st10", 1'b1, 1'b0, 19'h10, '1, 64'h1122_3344_5566_7788, lat);
    check_lat("st10_lat", lat, WL);
    do_op("ld10", 1'b0, 1'b0, 19'h10, '0, '0, lat);
    check_lat("ld10_lat", lat, RL);
    check("ld10_data", bus.ddr_opload_read_data, 64'h1122_3344_5566_7788);

    // 3. Low-half mask store of all-ones.
    do_op("stmask", 1'b1, 1'b0, 19'h10, 64'h0000_0000_FFFF_FFFF, '1, lat);
    do_op("ldmask", 1'b0, 1'b0, 19'h10, '0, '0, lat);
    check("ldmask_data", bus.ddr_opload_read_data, 64'h1122_3344_FFFF_FFFF);

    // Zero mask is a no-op store.
    do_op("stzero", 1'b1, 1'b0, 19'h10, '0, '0, lat);
    check_lat("stzero_lat", lat, WL);
    do_op("ldzero", 1'b0, 1'b0, 19'h10, '0, '0, lat);
    check("ldzero_data", bus.ddr_opload_read_data, 64'h1122_3344_FFFF_FFFF);

    // Store with burst flag behaves as a single store.
    do_op("stburst", 1'b1, 1'b1, 19'h20, '1, 64'hDEAD_BEEF_0BAD_F00D, lat);
    check_lat("stburst_lat", lat, WL);
    do_op("ld20", 1'b0, 1'b0, 19'h20, '0, '0, lat);
    check("ld20_data", bus.ddr_opload_read_data, 64'hDEAD_BEEF_0BAD_F00D);
    check("inst_untouched", bus.ddr_pc_read_inst, 0);

    // Upper index bits are ignored (0x40010 aliases 0x10).
    do_op("ldalias", 1'b0, 1'b0, 19'h4_0010, '0, '0, lat);
    check("ldalias_data", bus.ddr_opload_read_data, 64'h1122_3344_FFFF_FFFF);

    // 4. Preload mem[w]=w around the top of the array, then a wrapping burst.
    exp_inst = '0;
    for (int k = 0; k < BEATS; k++) begin
      w = 19'((DEPTH - 3 + k) % DEPTH);
      do_op("preload", 1'b1, 1'b0, w, '1, {45'd0, w}, lat);
      exp_inst[k*64 +: 64] = {45'd0, w};
    end
    do_op("burst", 1'b0, 1'b1, 19'(DEPTH - 3), '0, '0, lat);
    check_lat("burst_lat", lat, RL + BEATS);
    check("burst_data", bus.ddr_pc_read_inst, exp_inst);
    check("load_held", bus.ddr_opload_read_data, 64'h1122_3344_FFFF_FFFF);
    @(negedge clock);
    check("done_one_cycle", bus.ddr_operation_done, 0);
    check("burst_held", bus.ddr_pc_read_inst, exp_inst);

    // 5a. ce pulsed while busy (a clobbering store) is ignored.
    bus.ddr_chip_enable  = 1'b1;
    bus.ddr_write_enable = 1'b0;
    bus.ddr_burst_mode   = 1'b0;
    bus.ddr_index        = 19'h10;
    @(negedge clock);
    bus.ddr_chip_enable = 1'b0;
    dones = 0;
    for (int c = 1; c <= 12; c++) begin
      if (c == 2) begin
        bus.ddr_chip_enable        = 1'b1;
        bus.ddr_write_enable       = 1'b1;
        bus.ddr_opstore_write_mask = '1;
        bus.ddr_opstore_write_data = '0;
      end else begin
        bus.ddr_chip_enable = 1'b0;
      end
      if (bus.ddr_operation_done === 1'b1) dones++;
      @(negedge clock);
    end
    bus.ddr_chip_enable = 1'b0;
    $display("busy-ce window: done pulses=%0d", dones);
    check("busy_done_count", dones, 1);
    check("busy_load_data", bus.ddr_opload_read_data, 64'h1122_3344_FFFF_FFFF);
    do_op("ldbusy", 1'b0, 1'b0, 19'h10, '0, '0, lat);
    check("busy_store_ignored", bus.ddr_opload_read_data, 64'h1122_3344_FFFF_FFFF);

    // 5b. Reset during the WAIT of a store discards it.
    @(negedge clock);
    bus.ddr_chip_enable        = 1'b1;
    bus.ddr_write_enable       = 1'b1;
    bus.ddr_index              = 19'h10;
    bus.ddr_opstore_write_mask = '1;
    bus.ddr_opstore_write_data = '0;
    @(negedge clock);
    bus.ddr_chip_enable = 1'b0;
    reset = 1'b1;
    dones = 0;
    repeat (2) begin
      @(negedge clock);
      if (bus.ddr_operation_done === 1'b1) dones++;
    end
    reset = 1'b0;
    @(negedge clock);
    $display("mid-op reset: done pulses=%0d", dones);
    check("rst_mid_no_done", dones, 0);
    check("rst_mid_ready", bus.ddr_ready, 1);
    check("rst_mid_load_clr", bus.ddr_opload_read_data, 0);
    check("rst_mid_inst_clr", bus.ddr_pc_read_inst, 0);
    do_op("ldafter", 1'b0, 1'b0, 19'h10, '0, '0, lat);
    check("rst_store_dropped", bus.ddr_opload_read_data, 64'h1122_3344_FFFF_FFFF);

`ifdef DDR_RESP_JITTER_EN
    // 6. Random loads of preloaded words under latency jitter.
    for (int n = 0; n < 100; n++) begin
      w = 19'((DEPTH - 3 + int'($urandom_range(0, BEATS - 1))) % DEPTH);
      do_op("jit_ld", 1'b0, 1'b0, w, '0, '0, lat);
      check_lat("jit_lat", lat, RL);
      check("jit_data", bus.ddr_opload_read_data, {45'd0, w});
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
